// File: rtl/mips_regfile_sb_pkg.sv
// Shared types and defaults for the mips_regfile_sb register file and its scoreboard.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;
    localparam int R0_IDX     = 0;

    // R0 and indices beyond the implemented depth never hold state.
    function automatic logic addr_legal(input int addr, input int depth);
        return (addr != R0_IDX) && (addr < depth);
    endfunction

endpackage

// File: rtl/mips_regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reservation, cleared on writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_all,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic              o_busy1,
    output logic              o_busy2
);

    logic [DEPTH-1:0] r_pending;

    // Reserve is applied after the writeback clear so a newer producer wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else if (i_clr_all) begin
            r_pending <= '0;
        end else begin
            if (i_wr_en)
                r_pending[i_wr_addr] <= 1'b0;
            if (i_rsv_en)
                r_pending[i_rsv_addr] <= 1'b1;
        end
    end

    always_comb begin
        o_busy1 = 1'b0;
        o_busy2 = 1'b0;
        if (addr_legal(int'(i_rd_addr1), DEPTH))
            o_busy1 = r_pending[i_rd_addr1];
        if (addr_legal(int'(i_rd_addr2), DEPTH))
            o_busy2 = r_pending[i_rd_addr2];
    end

endmodule

// File: rtl/mips_regfile_sb.sv
// Register file with R0 tied to zero, pending-write scoreboard and sequential sweep clear.
// Optional write-first forwarding is enabled by defining REGFILE_BYPASS_EN.
module mips_regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              busy1,
    output logic              busy2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_clr_done;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic w_idle;
    logic w_wr_ok;
    logic w_rsv_ok;
    logic w_clr_start;
    logic w_last;
    logic w_sb_busy1;
    logic w_sb_busy2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_idle      = (r_state == IDLE);
    assign w_wr_ok     = w_idle && WE3 && addr_legal(int'(A3), DEPTH);
    assign w_rsv_ok    = w_idle && rsv_en && addr_legal(int'(rsv_addr), DEPTH);
    assign w_clr_start = w_idle && clr_req;
    assign w_last      = (r_cnt == ADDR_W'(DEPTH - 1));

    // Sweep starts at 1 because R0 is never written and already reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_clr_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_wr_ok)
                        r_regs[A3] <= WD3;
                    if (w_clr_start) begin
                        r_state <= SWEEP;
                        r_cnt   <= ADDR_W'(1);
                    end
                end
                SWEEP: begin
                    r_regs[r_cnt] <= '0;
                    if (w_last) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_clr_all  (w_clr_start),
        .i_wr_en    (w_wr_ok),
        .i_wr_addr  (A3),
        .i_rsv_en   (w_rsv_ok),
        .i_rsv_addr (rsv_addr),
        .i_rd_addr1 (A1),
        .i_rd_addr2 (A2),
        .o_busy1    (w_sb_busy1),
        .o_busy2    (w_sb_busy2)
    );

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (addr_legal(int'(A1), DEPTH))
            w_rd1 = r_regs[A1];
        if (addr_legal(int'(A2), DEPTH))
            w_rd2 = r_regs[A2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (A3 == A1))
            w_rd1 = WD3;
        if (w_wr_ok && (A3 == A2))
            w_rd2 = WD3;
`endif
    end

    assign RD1 = w_rd1;
    assign RD2 = w_rd2;

`ifdef REGFILE_BYPASS_EN
    // A forwarded write retires the old producer; only a same-cycle reserve keeps it busy.
    assign busy1 = (w_wr_ok && (A3 == A1)) ? (w_rsv_ok && (rsv_addr == A1)) : w_sb_busy1;
    assign busy2 = (w_wr_ok && (A3 == A2)) ? (w_rsv_ok && (rsv_addr == A2)) : w_sb_busy2;
`else
    assign busy1 = w_sb_busy1;
    assign busy2 = w_sb_busy2;
`endif

    assign clr_busy = (r_state == SWEEP);
    assign clr_done = r_clr_done;

endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- Parametrised successor to the single-cycle MIPS register file.
- Register file with configurable data width and depth, R0 hardwired to zero, and a per-register pending-write scoreboard for the upcoming pipelined core.
- Includes a sequential clear engine that zeroes the array without global reset.
- Sits between decode (reads, reservations) and writeback (WE3 port).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- DEPTH, 32, number of registers; must be ≤ 2**ADDR_W and ≥ 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- WE3  in  1  writeback write enable
- A3  in  ADDR_W  writeback address
- WD3  in  DATA_W  writeback data
- A1  in  ADDR_W  read address, port 1
- A2  in  ADDR_W  read address, port 2
- RD1  out  DATA_W  read data, port 1
- RD2  out  DATA_W  read data, port 2
- busy1  out  1  pending write outstanding on A1
- busy2  out  1  pending write outstanding on A2
- rsv_en  in  1  reserve destination register (issue)
- rsv_addr  in  ADDR_W  register to mark pending
- clr_req  in  1  request sweep-clear of all registers
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes

Behaviour:
- Reset (rst=1, asynchronous):
  - all registers = 0, all pending bits = 0, state = IDLE, sweep counter = 0;
  - clr_busy = 0, clr_done = 0.
- Reads are combinational.
  - RDn = 0 when An = 0 or An ≥ DEPTH; otherwise RDn = reg[An].
  - busyn = pending[An]; always 0 for An = 0 or An ≥ DEPTH.
- Write: on posedge, if WE3 and state = IDLE and A3 ≠ 0 and A3 < DEPTH, then reg[A3] ← WD3 and pending[A3] ← 0. All other writes are dropped silently.
- Reserve: on posedge, if rsv_en and state = IDLE and rsv_addr ≠ 0 and rsv_addr < DEPTH, then pending[rsv_addr] ← 1.
- Reserve and writeback to the same address in the same cycle: the data is written and the pending bit ends at 1 (reserve wins; it belongs to a newer producer).
- State machine, IDLE / SWEEP:
  - IDLE → SWEEP when clr_req = 1. On that edge all pending bits clear and the counter loads 1.
  - In SWEEP, each cycle reg[cnt] ← 0 and cnt increments.
  - When cnt = DEPTH−1 the final register is cleared, the state returns to IDLE and clr_done pulses on the following cycle.
  - Sweep length is DEPTH−1 cycles. clr_busy = 1 exactly while state = SWEEP.
- During SWEEP:
  - WE3, rsv_en and clr_req are ignored.
  - Reads remain live and return the mid-sweep contents.
- rst asserted mid-sweep aborts immediately to the reset state; no clr_done pulse.
- Counter width is ADDR_W. No wrap, because the sweep terminates at DEPTH−1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If WE3 is asserted with a legal A3 in IDLE and A3 = An ≠ 0, then:
  - RDn = WD3 combinationally;
  - busyn = 0, unless the same-cycle reserve targets An, in which case busyn = 1.
- Not defined: a read in the cycle of its write returns the old value. The new value is visible from the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - state enum {IDLE, SWEEP};
  - the default DATA_W, ADDR_W and DEPTH constants;
  - the R0 index constant.
- One sub-module, regfile_scoreboard, holds the pending-bit vector, reserve/clear logic and busy lookups. The top level holds the data array, bypass logic and sweep FSM.

Test Plan:
- Write A3=5, WD3=0xDEADBEEF; next cycle A1=5 → RD1=0xDEADBEEF. Write A3=0, WD3=0x1234 → RD of A1=0 stays 0.
- rsv_en on rsv_addr=7 → busy1=1 for A1=7 until WE3 on A3=7. Then busy1=0 on the next cycle and RD1=WD3.
- Same cycle: rsv_en on rsv_addr=9 and WE3 on A3=9 with WD3=0x55 → reg[9]=0x55 and busy for address 9 = 1.
- Fill all registers with 0xFFFFFFFF, then pulse clr_req:
  - clr_busy is high for 31 cycles, then clr_done pulses once;
  - all reads return 0, and a WE3 attempted mid-sweep has no effect.
- Raise rst asynchronously mid-sweep (at cnt=10) → clr_busy drops without a clock edge, all registers read 0, and clr_done never pulses.
- With REGFILE_BYPASS_EN: WE3 on A3=3 with WD3=0xA5A5A5A5 and A2=3 in the same cycle → RD2=0xA5A5A5A5 in that cycle. Without the macro, RD2 returns the old value.
